branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage counterpart of the fetch-side BTB/gshare predictor.
- Carries each fetched instruction's prediction metadata (pc, predicted next pc, history snapshot) through IF/ID and ID/EX.
- Compares the prediction against the actual outcome in EX. On a mismatch it issues a registered flush and redirect.
- Returns one registered update packet per resolved control instruction to the predictor's update port, and keeps the committed global history used for recovery.

Parameters:
- XLEN, 32, address/data width.
- GHR_W, 5, global history width; must match the predictor index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  fetch slot holds a real instruction.
- if_pc  in  XLEN  fetched pc.
- if_pred_pc  in  XLEN  predictor's next-pc choice for if_pc.
- if_ghr  in  GHR_W  history used to index the predictor for if_pc.
- stall  in  1  load-use stall: hold IF/ID, insert a bubble into ID/EX.
- id_is_branch, id_is_jal, id_is_jalr  in  1 each  decoder class of the ID instruction; at most one is set.
- ex_bcond  in  1  ALU branch condition of the EX instruction.
- ex_pc_plus_imm  in  XLEN  branch/jal target.
- ex_reg_plus_imm  in  XLEN  jalr target before clearing bit 0.
- flush  out  1  kill IF/ID/EX wrong-path instructions.
- redirect_pc  out  XLEN  correct fetch pc, valid while flush=1.
- upd_valid  out  1  predictor update strobe.
- upd_pc  out  XLEN  resolved instruction pc.
- upd_ghr  out  GHR_W  history snapshot of that instruction.
- upd_target  out  XLEN  actual target.
- upd_taken  out  1  actual direction.
- commit_ghr  out  GHR_W  committed history, for restoring speculative history on flush.
- perf_ctrl_cnt  out  32  resolved control instructions (optional feature).
- perf_mispred_cnt  out  32  mispredictions (optional feature).

Behaviour:
- Reset: all metadata valid bits 0; FSM=RUN. All outputs 0: flush, redirect_pc, upd_*, commit_ghr, perf_*.
- IF/ID register:
  - Loads {if_valid, if_pc, if_pred_pc, if_ghr} each edge unless stall.
  - Cleared (valid=0) when flush=1; flush overrides stall.
- ID/EX register:
  - Loads the IF/ID contents plus the decoder class bits.
  - Loads valid=0 when stall or flush.
- EX resolution (combinational; only when ex_valid and FSM=RUN):
  - ctrl = branch|jal|jalr.
  - taken = (branch & ex_bcond) | jal | jalr.
  - target = jalr ? (ex_reg_plus_imm & ~1) : ex_pc_plus_imm.
  - actual = taken ? target : ex_pc + 4.
  - mispredict = (actual != ex_pred_pc). This includes a non-control instruction that got a stale BTB hit; its redirect is pc+4.
- Registered outputs, latency 1 after the resolving EX cycle:
  - On mispredict: flush=1 and redirect_pc=actual for exactly one cycle.
  - On ctrl: upd_valid=1 for one cycle with upd_pc=ex_pc, upd_ghr=ex_ghr, upd_target=target, upd_taken=taken.
  - On ctrl: commit_ghr <= {commit_ghr[GHR_W-2:0], taken}.
  - A non-control instruction never produces upd_valid and never changes commit_ghr.
- FSM:
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN unconditionally after one cycle.
  - In RECOVER, flush=1, the EX slot is wrong-path, and resolution is suppressed: no mispredict, no update, no commit.
- Stall with a valid EX instruction: EX still resolves in that cycle, and the bubble enters EX next cycle.
- Back-to-back control instructions: one update per cycle, no loss.
- Reset asserted mid-RECOVER: return to RUN with every register cleared the next cycle.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - perf_ctrl_cnt increments on each upd_valid.
  - perf_mispred_cnt increments on each mispredict, including non-control ones.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: no counter flops; both ports tied to 0.

Decomposition:
- Package bru_pkg holds:
  - XLEN and GHR_W defaults.
  - The FSM state enum {RUN, RECOVER}.
  - The ctrl-class encoding.
  - The metadata struct {valid, pc, pred_pc, ghr}.
- Natural sub-module bru_meta_stage: one metadata pipeline slot with load/stall/flush/bubble controls, instantiated twice.

Test Plan:
- Correctly predicted taken branch: pc=0x40, pred=0x80, bcond=1, imm target 0x80 -> no flush; next cycle upd_valid=1, upd_target=0x80, upd_taken=1; commit_ghr 00000->00001.
- Mispredicted not-taken branch: pc=0x40, pred=0x80, bcond=0 -> next cycle flush=1, redirect_pc=0x44; the following EX instruction is suppressed (no upd_valid); FSM back to RUN after one cycle.
- jalr: reg+imm=0x101, pred=0x44 -> redirect_pc=0x100, upd_target=0x100, upd_taken=1.
- Stale BTB hit on an add: pc=0x20, pred=0x60 -> flush, redirect_pc=0x24, upd_valid=0, commit_ghr unchanged.
- Stall and flush in the same cycle: flush wins, and IF/ID valid=0 next cycle.
- With BRU_PERF_CNT_EN: 10 branches, 3 mispredicted -> perf_ctrl_cnt=10, perf_mispred_cnt=3. Without the macro, both read 0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the EX-stage branch resolve unit.
// Optional perf counters are enabled with BRU_PERF_CNT_EN.
package bru_pkg;

  localparam int BRU_XLEN  = 32;
  localparam int BRU_GHR_W = 5;

  typedef enum logic {
    RUN,
    RECOVER
  } bru_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_BR,
    CLS_JAL,
    CLS_JALR
  } ctrl_cls_e;

  typedef struct packed {
    logic                 valid;
    logic [BRU_XLEN-1:0]  pc;
    logic [BRU_XLEN-1:0]  pred_pc;
    logic [BRU_GHR_W-1:0] ghr;
  } meta_t;

  function automatic ctrl_cls_e enc_cls(
    input logic br,
    input logic jal,
    input logic jalr
  );
    ctrl_cls_e c;
    c = CLS_NONE;
    unique case (1'b1)
      br:      c = CLS_BR;
      jal:     c = CLS_JAL;
      jalr:    c = CLS_JALR;
      default: c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bru_upd_if.sv
// Predictor update packet from the resolve unit to the
// fetch-side BTB/gshare update port.
interface bru_upd_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 5
);
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic [XLEN-1:0]  upd_target;
  logic             upd_taken;

  modport master (
    output upd_valid, upd_pc, upd_ghr,
    output upd_target, upd_taken
  );

  modport slave (
    input upd_valid, upd_pc, upd_ghr,
    input upd_target, upd_taken
  );
endinterface

// File: rtl/bru_meta_stage.sv
// One prediction-metadata pipeline slot (IF/ID or ID/EX).
// Kill beats load; a killed slot only drops its valid bit.
module bru_meta_stage
  import bru_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  logic  i_kill,
  input  meta_t i_d,
  output meta_t o_q
);

  meta_t r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_kill) begin
      r_q.valid <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: flush/redirect, predictor update,
// committed GHR. Perf counters exist only with BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = BRU_XLEN,
  parameter int GHR_W = BRU_GHR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_pred_pc,
  input  logic [GHR_W-1:0] if_ghr,
  input  logic             stall,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic             ex_bcond,
  input  logic [XLEN-1:0]  ex_pc_plus_imm,
  input  logic [XLEN-1:0]  ex_reg_plus_imm,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  bru_upd_if.master        upd,
  output logic [GHR_W-1:0] commit_ghr,
  output logic [31:0]      perf_ctrl_cnt,
  output logic [31:0]      perf_mispred_cnt
);

  meta_t      w_if_d;
  meta_t      w_id_q;
  meta_t      w_ex_q;
  ctrl_cls_e  r_ex_cls;
  bru_state_e r_state;

  logic             r_flush;
  logic [XLEN-1:0]  r_redirect;
  logic             r_upd_valid;
  logic [XLEN-1:0]  r_upd_pc;
  logic [GHR_W-1:0] r_upd_ghr;
  logic [XLEN-1:0]  r_upd_target;
  logic             r_upd_taken;
  logic [GHR_W-1:0] r_commit;

  assign w_if_d = '{
    valid:   if_valid,
    pc:      if_pc,
    pred_pc: if_pred_pc,
    ghr:     if_ghr
  };

  bru_meta_stage u_if_id (
    .clk    (clk),
    .reset  (reset),
    .i_load (~stall),
    .i_kill (r_flush),
    .i_d    (w_if_d),
    .o_q    (w_id_q)
  );

  bru_meta_stage u_id_ex (
    .clk    (clk),
    .reset  (reset),
    .i_load (1'b1),
    .i_kill (stall | r_flush),
    .i_d    (w_id_q),
    .o_q    (w_ex_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_ex_cls <= CLS_NONE;
    else r_ex_cls <= enc_cls(id_is_branch, id_is_jal, id_is_jalr);
  end

  logic            w_res_en;
  logic            w_br;
  logic            w_jal;
  logic            w_jalr;
  logic            w_ctrl;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_actual;
  logic            w_mispred;
  logic            w_upd;

  // RECOVER means the EX slot is wrong-path, so nothing resolves
  assign w_res_en  = w_ex_q.valid & (r_state == RUN);
  assign w_br      = (r_ex_cls == CLS_BR);
  assign w_jal     = (r_ex_cls == CLS_JAL);
  assign w_jalr    = (r_ex_cls == CLS_JALR);
  assign w_ctrl    = w_br | w_jal | w_jalr;
  assign w_taken   = (w_br & ex_bcond) | w_jal | w_jalr;
  assign w_target  = w_jalr ? (ex_reg_plus_imm & ~XLEN'(1))
                            : ex_pc_plus_imm;
  assign w_actual  = w_taken ? w_target : w_ex_q.pc + XLEN'(4);
  assign w_mispred = w_res_en & (w_actual != w_ex_q.pred_pc);
  assign w_upd     = w_res_en & w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_flush      <= 1'b0;
      r_redirect   <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_ghr    <= '0;
      r_upd_target <= '0;
      r_upd_taken  <= 1'b0;
      r_commit     <= '0;
    end else begin
      r_flush     <= 1'b0;
      r_upd_valid <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (w_mispred) begin
            r_state    <= RECOVER;
            r_flush    <= 1'b1;
            r_redirect <= w_actual;
          end
        end
        RECOVER: r_state <= RUN;
      endcase
      if (w_upd) begin
        r_upd_valid  <= 1'b1;
        r_upd_pc     <= w_ex_q.pc;
        r_upd_ghr    <= w_ex_q.ghr;
        r_upd_target <= w_target;
        r_upd_taken  <= w_taken;
        r_commit     <= {r_commit[GHR_W-2:0], w_taken};
      end
    end
  end

  assign flush          = r_flush;
  assign redirect_pc    = r_redirect;
  assign upd.upd_valid  = r_upd_valid;
  assign upd.upd_pc     = r_upd_pc;
  assign upd.upd_ghr    = r_upd_ghr;
  assign upd.upd_target = r_upd_target;
  assign upd.upd_taken  = r_upd_taken;
  assign commit_ghr     = r_commit;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_ctrl;
  logic [31:0] r_perf_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ctrl <= '0;
      r_perf_mis  <= '0;
    end else begin
      if (r_upd_valid && (r_perf_ctrl != '1))
        r_perf_ctrl <= r_perf_ctrl + 32'd1;
      if (w_mispred && (r_perf_mis != '1))
        r_perf_mis <= r_perf_mis + 32'd1;
    end
  end

  assign perf_ctrl_cnt    = r_perf_ctrl;
  assign perf_mispred_cnt = r_perf_mis;
`else
  assign perf_ctrl_cnt    = 32'd0;
  assign perf_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; expectations come
// from a per-instruction pipeline model of the resolve rules.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pred_pc;
  logic [4:0]  if_ghr;
  logic        stall;
  logic        id_is_branch;
  logic        id_is_jal;
  logic        id_is_jalr;
  logic        ex_bcond;
  logic [31:0] ex_pc_plus_imm;
  logic [31:0] ex_reg_plus_imm;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [4:0]  commit_ghr;
  logic [31:0] perf_ctrl_cnt;
  logic [31:0] perf_mispred_cnt;

  bru_upd_if #(.XLEN(32), .GHR_W(5)) u_upd ();

  branch_resolve_unit #(.XLEN(32), .GHR_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_pred_pc       (if_pred_pc),
    .if_ghr           (if_ghr),
    .stall            (stall),
    .id_is_branch     (id_is_branch),
    .id_is_jal        (id_is_jal),
    .id_is_jalr       (id_is_jalr),
    .ex_bcond         (ex_bcond),
    .ex_pc_plus_imm   (ex_pc_plus_imm),
    .ex_reg_plus_imm  (ex_reg_plus_imm),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .upd              (u_upd),
    .commit_ghr       (commit_ghr),
    .perf_ctrl_cnt    (perf_ctrl_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  always #5 clk = ~clk;

`ifdef BRU_PERF_CNT_EN
  localparam logic [31:0] EXP_CTRL = 32'd10;
  localparam logic [31:0] EXP_MIS  = 32'd3;
`else
  localparam logic [31:0] EXP_CTRL = 32'd0;
  localparam logic [31:0] EXP_MIS  = 32'd0;
`endif

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] pred;
    logic [4:0]  ghr;
    bit          br;
    bit          jal;
    bit          jalr;
    bit          bc;
    logic [31:0] pimm;
    logic [31:0] rimm;
  } ins_t;

  typedef struct {
    bit          fl;
    logic [31:0] rd;
    bit          uv;
    logic [31:0] upc;
    logic [4:0]  ughr;
    logic [31:0] utg;
    bit          utk;
    logic [4:0]  cg;
  } exp_t;

  ins_t prog[$];
  bit   stq[$];
  exp_t sb[$];

  ins_t        m_id;
  ins_t        m_ex;
  bit          m_rec;
  logic [4:0]  m_cg;

  int          checks = 0;
  int          failures = 0;
  int          n_upd;
  int          n_flush;
  logic [31:0] last_rd;
  logic [31:0] last_utg;
  logic        last_utk;

  function automatic ins_t mk(
    input logic [31:0] pc, input logic [31:0] pred,
    input bit br, input bit jal, input bit jalr, input bit bc,
    input logic [31:0] pimm, input logic [31:0] rimm,
    input logic [4:0] ghr
  );
    ins_t x;
    x.v = 1'b1; x.pc = pc; x.pred = pred; x.ghr = ghr;
    x.br = br; x.jal = jal; x.jalr = jalr; x.bc = bc;
    x.pimm = pimm; x.rimm = rimm;
    return x;
  endfunction

  function automatic ins_t bubble();
    ins_t x;
    x = '{default: 0};
    return x;
  endfunction

  task automatic drive_idle();
    if_valid = 0; if_pc = 0; if_pred_pc = 0; if_ghr = 0;
    stall = 0; id_is_branch = 0; id_is_jal = 0; id_is_jalr = 0;
    ex_bcond = 0; ex_pc_plus_imm = 0; ex_reg_plus_imm = 0;
  endtask

  task automatic model_reset();
    m_id = bubble(); m_ex = bubble();
    m_rec = 0; m_cg = 5'd0;
    sb.delete();
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n, input string tag);
    int          k;
    ins_t        ci;
    bit          st, res, ctrl, tk, mis, fnow;
    logic [31:0] tg, act;
    exp_t        e;
    k = 0; n_upd = 0; n_flush = 0;
    for (int c = 0; c < n; c++) begin
      ci = (k < prog.size()) ? prog[k] : bubble();
      st = (c < stq.size()) ? stq[c] : 1'b0;
      if_valid = ci.v; if_pc = ci.pc;
      if_pred_pc = ci.pred; if_ghr = ci.ghr;
      stall = st;
      id_is_branch = m_id.v & m_id.br;
      id_is_jal = m_id.v & m_id.jal;
      id_is_jalr = m_id.v & m_id.jalr;
      ex_bcond = m_ex.bc;
      ex_pc_plus_imm = m_ex.pimm;
      ex_reg_plus_imm = m_ex.rimm;
      res  = m_ex.v && !m_rec;
      ctrl = m_ex.br | m_ex.jal | m_ex.jalr;
      tk   = (m_ex.br & m_ex.bc) | m_ex.jal | m_ex.jalr;
      tg   = m_ex.jalr ? {m_ex.rimm[31:1], 1'b0} : m_ex.pimm;
      act  = tk ? tg : m_ex.pc + 32'd4;
      mis  = res && (act != m_ex.pred);
      e.fl = mis; e.rd = act;
      e.uv = res && ctrl; e.upc = m_ex.pc; e.ughr = m_ex.ghr;
      e.utg = tg; e.utk = tk;
      if (res && ctrl) m_cg = {m_cg[3:0], tk};
      e.cg = m_cg;
      sb.push_back(e);
      fnow = m_rec;
      m_rec = mis;
      m_ex = (st || fnow) ? bubble() : m_id;
      if (fnow) m_id = bubble();
      else if (!st) m_id = ci;
      if (!st) k++;
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      if (flush) n_flush++;
      if (u_upd.upd_valid) n_upd++;
      checks++;
      if (flush !== e.fl) begin
        failures++;
        $display("FAIL %s.flush cyc=%0d got=%b exp=%b",
                 tag, c, flush, e.fl);
      end
      if (e.fl) begin
        last_rd = redirect_pc;
        checks++;
        if (redirect_pc !== e.rd) begin
          failures++;
          $display("FAIL %s.redirect cyc=%0d got=%h exp=%h",
                   tag, c, redirect_pc, e.rd);
        end
      end
      checks++;
      if (u_upd.upd_valid !== e.uv) begin
        failures++;
        $display("FAIL %s.upd_valid cyc=%0d got=%b exp=%b",
                 tag, c, u_upd.upd_valid, e.uv);
      end
      if (e.uv) begin
        last_utg = u_upd.upd_target;
        last_utk = u_upd.upd_taken;
        checks++;
        if ({u_upd.upd_pc, u_upd.upd_ghr, u_upd.upd_target,
             u_upd.upd_taken} !==
            {e.upc, e.ughr, e.utg, e.utk}) begin
          failures++;
          $display("FAIL %s.upd_pkt cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                   tag, c, u_upd.upd_pc, u_upd.upd_ghr,
                   u_upd.upd_target, u_upd.upd_taken,
                   e.upc, e.ughr, e.utg, e.utk);
        end
      end
      checks++;
      if (commit_ghr !== e.cg) begin
        failures++;
        $display("FAIL %s.commit_ghr cyc=%0d got=%b exp=%b",
                 tag, c, commit_ghr, e.cg);
      end
    end
    prog.delete(); stq.delete();
    drive_idle();
  endtask

  task automatic test_reset();
    if_valid = 1; if_pc = 32'h40; if_pred_pc = 32'h44;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_idle();
    checks++;
    if ({flush, redirect_pc, u_upd.upd_valid, u_upd.upd_pc,
         u_upd.upd_ghr, u_upd.upd_target, u_upd.upd_taken,
         commit_ghr, perf_ctrl_cnt, perf_mispred_cnt} !== '0) begin
      failures++;
      $display("FAIL reset.outputs got fl=%b rd=%h uv=%b cg=%b pc=%0d pm=%0d exp=all0",
               flush, redirect_pc, u_upd.upd_valid, commit_ghr,
               perf_ctrl_cnt, perf_mispred_cnt);
    end
  endtask

  task automatic test_pred_taken();
    prog.push_back(mk(32'h40, 32'h80, 1, 0, 0, 1,
                      32'h80, 32'h0, 5'b00110));
    run(5, "pred_taken");
    checks++;
    if (commit_ghr !== 5'b00001 || n_upd != 1 || n_flush != 0) begin
      failures++;
      $display("FAIL pred_taken.summary got cg=%b upd=%0d fl=%0d exp cg=00001 upd=1 fl=0",
               commit_ghr, n_upd, n_flush);
    end
  endtask

  task automatic test_mispred_nt();
    prog.push_back(mk(32'h40, 32'h80, 1, 0, 0, 0,
                      32'h80, 32'h0, 5'b00001));
    prog.push_back(mk(32'h80, 32'h84, 1, 0, 0, 1,
                      32'hC0, 32'h0, 5'b00010));
    prog.push_back(mk(32'h84, 32'h88, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(32'h88, 32'h8C, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(32'h44, 32'h48, 1, 0, 0, 0,
                      32'h90, 32'h0, 5'b00011));
    run(9, "mispred_nt");
    checks++;
    if (n_flush != 1 || n_upd != 2 || last_rd !== 32'h44) begin
      failures++;
      $display("FAIL mispred_nt.summary got fl=%0d upd=%0d rd=%h exp fl=1 upd=2 rd=44",
               n_flush, n_upd, last_rd);
    end
  endtask

  task automatic test_jalr();
    prog.push_back(mk(32'h48, 32'h44, 0, 0, 1, 0,
                      32'h0, 32'h101, 5'b00100));
    run(5, "jalr");
    checks++;
    if (last_rd !== 32'h100 || last_utg !== 32'h100 ||
        last_utk !== 1'b1 || n_flush != 1) begin
      failures++;
      $display("FAIL jalr.summary got rd=%h tg=%h tk=%b fl=%0d exp rd=100 tg=100 tk=1 fl=1",
               last_rd, last_utg, last_utk, n_flush);
    end
  endtask

  task automatic test_stale_btb();
    logic [4:0] cg0;
    cg0 = m_cg;
    prog.push_back(mk(32'h20, 32'h60, 0, 0, 0, 0,
                      32'h0, 32'h0, 5'b0));
    run(5, "stale_btb");
    checks++;
    if (n_upd != 0 || n_flush != 1 || last_rd !== 32'h24 ||
        commit_ghr !== cg0) begin
      failures++;
      $display("FAIL stale_btb.summary got upd=%0d fl=%0d rd=%h cg=%b exp upd=0 fl=1 rd=24 cg=%b",
               n_upd, n_flush, last_rd, commit_ghr, cg0);
    end
  endtask

  task automatic test_stall_flush();
    prog.push_back(mk(32'h10, 32'h14, 1, 0, 0, 1,
                      32'h30, 32'h0, 5'b0));
    prog.push_back(mk(32'h14, 32'h18, 0, 1, 0, 0,
                      32'h90, 32'h0, 5'b0));
    prog.push_back(mk(32'h18, 32'h1C, 0, 1, 0, 0,
                      32'h94, 32'h0, 5'b0));
    prog.push_back(mk(32'h1C, 32'h20, 0, 0, 0, 0, 0, 0, 0));
    stq = '{0, 0, 0, 1, 0};
    run(9, "stall_flush");
    checks++;
    if (n_upd != 1 || n_flush != 1 || last_rd !== 32'h30) begin
      failures++;
      $display("FAIL stall_flush.summary got upd=%0d fl=%0d rd=%h exp upd=1 fl=1 rd=30",
               n_upd, n_flush, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = 32'h100 + 32'(4 * i);
      prog.push_back(mk(p, p + 32'd4, 1, 0, 0, 0,
                        p + 32'h40, 32'h0, 5'(i)));
    end
    prog.push_back(mk(32'h110, 32'h200, 0, 1, 0, 0,
                      32'h200, 32'h0, 5'd9));
    stq = '{0, 0, 0, 1, 0};
    run(10, "back_to_back");
    checks++;
    if (n_upd != 5 || n_flush != 0 || commit_ghr !== 5'b00001) begin
      failures++;
      $display("FAIL back_to_back.summary got upd=%0d fl=%0d cg=%b exp upd=5 fl=0 cg=00001",
               n_upd, n_flush, commit_ghr);
    end
  endtask

  task automatic test_reset_recover();
    prog.push_back(mk(32'h300, 32'h340, 1, 0, 0, 1,
                      32'h340, 32'h0, 5'b0));
    run(5, "rr_pre");
    prog.push_back(mk(32'h340, 32'h380, 1, 0, 0, 0,
                      32'h380, 32'h0, 5'b0));
    run(3, "rr_mis");
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL reset_recover.in_recover got fl=%b exp=1", flush);
    end
    do_reset();
    checks++;
    if ({flush, u_upd.upd_valid, commit_ghr, redirect_pc} !== '0) begin
      failures++;
      $display("FAIL reset_recover.cleared got fl=%b uv=%b cg=%b rd=%h exp=all0",
               flush, u_upd.upd_valid, commit_ghr, redirect_pc);
    end
    prog.push_back(mk(32'h500, 32'h540, 1, 0, 0, 1,
                      32'h540, 32'h0, 5'b0));
    run(5, "rr_post");
    checks++;
    if (n_upd != 1 || n_flush != 0 || commit_ghr !== 5'b00001) begin
      failures++;
      $display("FAIL reset_recover.run got upd=%0d fl=%0d cg=%b exp upd=1 fl=0 cg=00001",
               n_upd, n_flush, commit_ghr);
    end
  endtask

  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p;
      bit          m;
      p = 32'h200 + 32'(16 * i);
      m = (i % 4 == 0);
      prog.push_back(mk(p, p + 32'd4, 1, 0, 0, m,
                        p + 32'h40, 32'h0, 5'(i)));
      run(5, "perf");
    end
    checks++;
    if (perf_ctrl_cnt !== EXP_CTRL) begin
      failures++;
      $display("FAIL perf.ctrl got=%0d exp=%0d", perf_ctrl_cnt, EXP_CTRL);
    end
    checks++;
    if (perf_mispred_cnt !== EXP_MIS) begin
      failures++;
      $display("FAIL perf.mispred got=%0d exp=%0d",
               perf_mispred_cnt, EXP_MIS);
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    last_rd = 0; last_utg = 0; last_utk = 0;
    n_upd = 0; n_flush = 0;
    @(negedge clk);
    test_reset();
    test_pred_taken();
    test_mispred_nt();
    test_jalr();
    test_stale_btb();
    test_stall_flush();
    test_back_to_back();
    test_reset_recover();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
